prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: program-memory capacity in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 1000000: maximum idle cycles allowed between accepted bytes while a load is in progress.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rxValid, input, 1: rxByte holds a valid byte.
REQ-006 SHALL have port rxByte, input, 8: incoming serial byte.
REQ-007 SHALL have port rxReady, output, 1: loader can accept a byte; a byte is accepted only when rxValid & rxReady.
REQ-008 SHALL have port pmWriteEn, output, 1: one-cycle program-memory write strobe.
REQ-009 SHALL have port pmAddr, output, 64: byte address of the write, matching the 64-bit PC domain.
REQ-010 SHALL have port pmData, output, 32: instruction word to write.
REQ-011 SHALL have port cpuReset, output, 1: holds the core (PC, registers) in reset until the load completes.
REQ-012 SHALL have port loadDone, output, 1: load completed successfully (sticky).
REQ-013 SHALL have port loadError, output, 1: load aborted (sticky).

Function
REQ-014 SHALL implement FSM states IDLE, CNT_LO, CNT_HI, DATA, DONE, ERROR.
REQ-015 In IDLE, rxReady=1; accepted byte 0xA5 -> CNT_LO; any other accepted byte is discarded, state stays IDLE.
REQ-016 In CNT_LO, the accepted byte -> count[7:0], then CNT_HI; in CNT_HI, the accepted byte -> count[15:8].
REQ-017 On leaving CNT_HI: count==0 -> DONE; count>MAX_WORDS -> ERROR; otherwise -> DATA with wordIdx=0, byteIdx=0.
REQ-018 In DATA, bytes assemble little-endian: byteIdx 0..3 -> bits [7:0],[15:8],[23:16],[31:24].
REQ-019 On acceptance of byte 3, the next cycle SHALL present pmWriteEn=1 for exactly one cycle, with pmData = assembled word and pmAddr = wordIdx*4 (zero-extended to 64 bits).
REQ-020 rxReady SHALL be 0 during the pmWriteEn cycle, so at most one word is in flight.
REQ-021 After the write of wordIdx==count-1: -> DONE; otherwise wordIdx increments and byteIdx wraps to 0.
REQ-022 In CNT_LO, CNT_HI and DATA, a 32-bit idle counter SHALL clear on each accepted byte and increment otherwise; reaching TIMEOUT -> ERROR.
REQ-023 In DONE: rxReady=0, cpuReset=0, loadDone=1, no further writes; state holds until reset.
REQ-024 In ERROR: rxReady=0, cpuReset=1, loadError=1, no further writes; state holds until reset.
REQ-025 cpuReset SHALL be 1 in every state other than DONE.
REQ-026 pmWriteEn SHALL never be asserted outside DATA-related write cycles, and never in the same cycle as a state change into DONE or ERROR from a non-write condition.
REQ-027 rxValid while rxReady=0 SHALL be ignored; no byte is consumed.

Reset
REQ-028 While reset is high, regardless of clk: state=IDLE, rxReady=1, pmWriteEn=0, pmAddr=0, pmData=0, cpuReset=1, loadDone=0, loadError=0, and all counters=0.
REQ-029 Reset asserted mid-load SHALL abort the load with no further write strobe; after release the loader requires a new 0xA5.

Verification
REQ-030 Bytes A5,02,00,13,05,10,00,93,05,20,00 -> writes (addr 0x0, data 0x00100513), (addr 0x4, data 0x00200593); then loadDone=1 and cpuReset=0.
REQ-031 Bytes 00,FF,A5,00,00 -> first two bytes discarded; DONE entered with no pmWriteEn pulse.
REQ-032 With MAX_WORDS=256, bytes A5,01,01 (count=257) -> ERROR, loadError=1, cpuReset stays 1, zero writes.
REQ-033 With TIMEOUT=16, bytes A5,01,00,AA then silence -> ERROR exactly 16 cycles after the AA byte is accepted.
REQ-034 rxValid held high continuously across a word boundary -> rxReady=0 in the write cycle; no byte is lost or duplicated; pmData correct.
REQ-035 Reset pulsed after the 2nd data byte, then full sequence from REQ-030 -> exactly the two writes of REQ-030, starting at addr 0x0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: serial program loader. Waits for a 0xA5 sync byte, then a
// 16-bit little-endian word count, then that many 32-bit little-endian
// instruction words, each written to program memory at its byte address.
// The core is held in reset until the load finishes.
//
// state  | meaning
// IDLE   | waiting for the 0xA5 sync byte, other bytes discarded
// CNT_LO | receiving word count bits [7:0]
// CNT_HI | receiving word count bits [15:8], then range check
// DATA   | receiving instruction bytes / issuing one-cycle writes
// DONE   | load complete, core released, sticky until reset
// ERROR  | load aborted (too many words or idle timeout), sticky
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   rxValid/rxByte      - incoming byte stream
//   rxReady             - byte accepted when rxValid & rxReady
//   pmWriteEn/pmAddr/pmData - program-memory write port (64-bit byte address)
//   cpuReset            - core reset, released only in DONE
//   loadDone/loadError  - sticky status flags
module prog_loader #(
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    output logic        rxReady,
    output logic        pmWriteEn,
    output logic [63:0] pmAddr,
    output logic [31:0] pmData,
    output logic        cpuReset,
    output logic        loadDone,
    output logic        loadError
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);
    localparam logic [31:0] MAX_W      = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] idle_q, idle_d;
    logic        rx_ready_q, rx_ready_d;
    logic        pm_write_en_q, pm_write_en_d;
    logic [63:0] pm_addr_q, pm_addr_d;
    logic [31:0] pm_data_q, pm_data_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;

    logic        accept;
    logic [15:0] count_full;
    logic        timeout_hit;

    assign accept      = rxValid & rx_ready_q;
    assign count_full  = {rxByte, count_q[7:0]};
    // Terminal count: the idle counter would reach TIMEOUT on this edge.
    assign timeout_hit = !accept && (idle_q >= TIMEOUT_M1);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        word_idx_d    = word_idx_q;
        byte_idx_d    = byte_idx_q;
        asm_d         = asm_q;
        idle_d        = idle_q;
        rx_ready_d    = rx_ready_q;
        pm_write_en_d = 1'b0;
        pm_addr_d     = pm_addr_q;
        pm_data_d     = pm_data_q;
        cpu_reset_d   = cpu_reset_q;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;

        case (state_q)
            IDLE: begin
                if (accept && rxByte == 8'hA5) begin
                    state_d = CNT_LO;
                    count_d = '0;
                    idle_d  = '0;
                end
            end

            CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = rxByte;
                    idle_d       = '0;
                    state_d      = CNT_HI;
                end else if (timeout_hit) begin
                    state_d      = ERROR;
                    rx_ready_d   = 1'b0;
                    load_error_d = 1'b1;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end

            CNT_HI: begin
                if (accept) begin
                    count_d = count_full;
                    idle_d  = '0;
                    if (count_full == 16'd0) begin
                        state_d     = DONE;
                        rx_ready_d  = 1'b0;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else if ({16'd0, count_full} > MAX_W) begin
                        state_d      = ERROR;
                        rx_ready_d   = 1'b0;
                        load_error_d = 1'b1;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d      = ERROR;
                    rx_ready_d   = 1'b0;
                    load_error_d = 1'b1;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end

            DATA: begin
                if (pm_write_en_q) begin
                    // Write cycle: rxReady is low so nothing can be accepted.
                    idle_d = idle_q + 32'd1;
                    if (word_idx_q == count_q - 16'd1) begin
                        state_d     = DONE;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                        byte_idx_d = '0;
                        rx_ready_d = 1'b1;
                    end
                end else if (accept) begin
                    idle_d = '0;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rxByte;
                        2'd1: asm_d[15:8]  = rxByte;
                        2'd2: asm_d[23:16] = rxByte;
                        default: begin
                            pm_write_en_d = 1'b1;
                            pm_data_d     = {rxByte, asm_q};
                            pm_addr_d     = {46'd0, word_idx_q, 2'b00};
                            rx_ready_d    = 1'b0;
                        end
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                end else if (timeout_hit) begin
                    state_d      = ERROR;
                    rx_ready_d   = 1'b0;
                    load_error_d = 1'b1;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end

            DONE: begin
                rx_ready_d = 1'b0;
            end

            ERROR: begin
                rx_ready_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            idle_q        <= '0;
            rx_ready_q    <= 1'b1;
            pm_write_en_q <= 1'b0;
            pm_addr_q     <= '0;
            pm_data_q     <= '0;
            cpu_reset_q   <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_idx_q    <= word_idx_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            idle_q        <= idle_d;
            rx_ready_q    <= rx_ready_d;
            pm_write_en_q <= pm_write_en_d;
            pm_addr_q     <= pm_addr_d;
            pm_data_q     <= pm_data_d;
            cpu_reset_q   <= cpu_reset_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
        end
    end

    assign rxReady   = rx_ready_q;
    assign pmWriteEn = pm_write_en_q;
    assign pmAddr    = pm_addr_q;
    assign pmData    = pm_data_q;
    assign cpuReset  = cpu_reset_q;
    assign loadDone  = load_done_q;
    assign loadError = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (MAX_WORDS=256, TIMEOUT=16).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxValid = 1'b0;
    logic [7:0]  rxByte = 8'h00;
    logic        rxReady;
    logic        pmWriteEn;
    logic [63:0] pmAddr;
    logic [31:0] pmData;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;

    int errors = 0;
    int checks = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          dbl_cnt = 0;   // write strobe seen on two consecutive cycles
    int          ovl_cnt = 0;   // write strobe seen together with rxReady
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.MAX_WORDS(256), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rxValid(rxValid), .rxByte(rxByte),
        .rxReady(rxReady), .pmWriteEn(pmWriteEn), .pmAddr(pmAddr),
        .pmData(pmData), .cpuReset(cpuReset), .loadDone(loadDone),
        .loadError(loadError)
    );

    always @(negedge clk) begin
        if (pmWriteEn === 1'b1) begin
            wr_addr.push_back(pmAddr);
            wr_data.push_back(pmData);
            if (prev_we) dbl_cnt++;
            if (rxReady === 1'b1) ovl_cnt++;
        end
        prev_we = (pmWriteEn === 1'b1);
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        rxValid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit ok;
        ok = 1'b0;
        rxByte = b;
        rxValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rxReady === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hold) rxValid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte_%h: accepted=0 required=1", b);
        end
    endtask

    task automatic send_list(input logic [7:0] seq[$], input bit hold);
        foreach (seq[i]) send_byte(seq[i], hold);
        rxValid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (rxReady !== 1'b1) begin errors++; $display("FAIL rst_rxReady: got=%b exp=1", rxReady); end
        checks++; if (pmWriteEn !== 1'b0) begin errors++; $display("FAIL rst_pmWriteEn: got=%b exp=0", pmWriteEn); end
        checks++; if (pmAddr !== 64'd0) begin errors++; $display("FAIL rst_pmAddr: got=%h exp=0", pmAddr); end
        checks++; if (pmData !== 32'd0) begin errors++; $display("FAIL rst_pmData: got=%h exp=0", pmData); end
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL rst_cpuReset: got=%b exp=1", cpuReset); end
        checks++; if (loadDone !== 1'b0) begin errors++; $display("FAIL rst_loadDone: got=%b exp=0", loadDone); end
        checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL rst_loadError: got=%b exp=0", loadError); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic_load();
        logic [7:0] s1[$];
        int base;
        s1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20};
        do_reset();
        base = wr_addr.size();
        send_list(s1, 1'b0);
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL basic_mid_cpuReset: got=%b exp=1", cpuReset); end
        send_byte(8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wr_addr.size() - base != 2) begin errors++; $display("FAIL basic_nwrites: got=%0d exp=2", wr_addr.size() - base); end
        checks++; if ((wr_addr.size() > base ? wr_addr[base] : 64'hx) !== 64'h0) begin errors++; $display("FAIL basic_addr0: got=%h exp=0", (wr_addr.size() > base ? wr_addr[base] : 64'hx)); end
        checks++; if ((wr_data.size() > base ? wr_data[base] : 32'hx) !== 32'h00100513) begin errors++; $display("FAIL basic_data0: got=%h exp=00100513", (wr_data.size() > base ? wr_data[base] : 32'hx)); end
        checks++; if ((wr_addr.size() > base + 1 ? wr_addr[base+1] : 64'hx) !== 64'h4) begin errors++; $display("FAIL basic_addr1: got=%h exp=4", (wr_addr.size() > base + 1 ? wr_addr[base+1] : 64'hx)); end
        checks++; if ((wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx) !== 32'h00200593) begin errors++; $display("FAIL basic_data1: got=%h exp=00200593", (wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx)); end
        checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL basic_loadDone: got=%b exp=1", loadDone); end
        checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL basic_cpuReset: got=%b exp=0", cpuReset); end
        checks++; if (rxReady !== 1'b0) begin errors++; $display("FAIL basic_rxReady: got=%b exp=0", rxReady); end
        // DONE must ignore further traffic and stay put
        rxByte = 8'hA5;
        rxValid = 1'b1;
        repeat (6) @(posedge clk);
        #1 rxValid = 1'b0;
        checks++; if (wr_addr.size() - base != 2) begin errors++; $display("FAIL done_hold_nwrites: got=%0d exp=2", wr_addr.size() - base); end
        checks++; if (loadDone !== 1'b1 || loadError !== 1'b0) begin errors++; $display("FAIL done_hold_flags: got=%b%b exp=10", loadDone, loadError); end
    endtask

    task automatic test_discard();
        logic [7:0] s[$];
        int base;
        s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        do_reset();
        base = wr_addr.size();
        send_list(s, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL discard_loadDone: got=%b exp=1", loadDone); end
        checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL discard_cpuReset: got=%b exp=0", cpuReset); end
        checks++; if (wr_addr.size() - base != 0) begin errors++; $display("FAIL discard_nwrites: got=%0d exp=0", wr_addr.size() - base); end
    endtask

    task automatic test_too_big();
        logic [7:0] s[$];
        int base;
        s = '{8'hA5, 8'h01, 8'h01};
        do_reset();
        base = wr_addr.size();
        send_list(s, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (loadError !== 1'b1) begin errors++; $display("FAIL big_loadError: got=%b exp=1", loadError); end
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL big_cpuReset: got=%b exp=1", cpuReset); end
        checks++; if (loadDone !== 1'b0) begin errors++; $display("FAIL big_loadDone: got=%b exp=0", loadDone); end
        checks++; if (rxReady !== 1'b0) begin errors++; $display("FAIL big_rxReady: got=%b exp=0", rxReady); end
        checks++; if (wr_addr.size() - base != 0) begin errors++; $display("FAIL big_nwrites: got=%0d exp=0", wr_addr.size() - base); end
    endtask

    task automatic test_max_ok();
        // count == MAX_WORDS is legal: the loader must enter DATA, not ERROR
        logic [7:0] s[$];
        s = '{8'hA5, 8'h00, 8'h01};
        do_reset();
        send_list(s, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (loadError !== 1'b0 || rxReady !== 1'b1) begin errors++; $display("FAIL max_ok: got err=%b rdy=%b exp err=0 rdy=1", loadError, rxReady); end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        int base;
        s = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        do_reset();
        base = wr_addr.size();
        send_list(s, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL timeout_early: got=%b exp=0 at 15 cycles", loadError); end
        @(posedge clk);
        #1;
        checks++; if (loadError !== 1'b1) begin errors++; $display("FAIL timeout_at16: got=%b exp=1", loadError); end
        checks++; if (cpuReset !== 1'b1 || rxReady !== 1'b0) begin errors++; $display("FAIL timeout_outs: got cpu=%b rdy=%b exp cpu=1 rdy=0", cpuReset, rxReady); end
        checks++; if (wr_addr.size() - base != 0) begin errors++; $display("FAIL timeout_nwrites: got=%0d exp=0", wr_addr.size() - base); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        int base, d0, o0;
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_reset();
        base = wr_addr.size();
        d0 = dbl_cnt;
        o0 = ovl_cnt;
        send_list(s, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wr_addr.size() - base != 2) begin errors++; $display("FAIL b2b_nwrites: got=%0d exp=2", wr_addr.size() - base); end
        checks++; if ((wr_data.size() > base ? wr_data[base] : 32'hx) !== 32'h00100513) begin errors++; $display("FAIL b2b_data0: got=%h exp=00100513", (wr_data.size() > base ? wr_data[base] : 32'hx)); end
        checks++; if ((wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx) !== 32'h00200593) begin errors++; $display("FAIL b2b_data1: got=%h exp=00200593", (wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx)); end
        checks++; if ((wr_addr.size() > base + 1 ? wr_addr[base+1] : 64'hx) !== 64'h4) begin errors++; $display("FAIL b2b_addr1: got=%h exp=4", (wr_addr.size() > base + 1 ? wr_addr[base+1] : 64'hx)); end
        checks++; if (ovl_cnt - o0 != 0) begin errors++; $display("FAIL b2b_ready_in_write: got=%0d exp=0", ovl_cnt - o0); end
        checks++; if (dbl_cnt - d0 != 0) begin errors++; $display("FAIL b2b_strobe_width: got=%0d exp=0", dbl_cnt - d0); end
        checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL b2b_loadDone: got=%b exp=1", loadDone); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] pre[$];
        logic [7:0] s[$];
        int base;
        pre = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
        s   = '{8'h02, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_reset();
        base = wr_addr.size();
        send_list(pre, 1'b0);
        do_reset();
        #1;
        checks++; if (wr_addr.size() - base != 0 || rxReady !== 1'b1 || cpuReset !== 1'b1) begin errors++; $display("FAIL midrst_state: got nw=%0d rdy=%b cpu=%b exp nw=0 rdy=1 cpu=1", wr_addr.size() - base, rxReady, cpuReset); end
        // the leading 0x02 must be discarded: a new 0xA5 is required
        send_list(s, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wr_addr.size() - base != 2) begin errors++; $display("FAIL midrst_nwrites: got=%0d exp=2", wr_addr.size() - base); end
        checks++; if ((wr_addr.size() > base ? wr_addr[base] : 64'hx) !== 64'h0) begin errors++; $display("FAIL midrst_addr0: got=%h exp=0", (wr_addr.size() > base ? wr_addr[base] : 64'hx)); end
        checks++; if ((wr_data.size() > base ? wr_data[base] : 32'hx) !== 32'h00100513) begin errors++; $display("FAIL midrst_data0: got=%h exp=00100513", (wr_data.size() > base ? wr_data[base] : 32'hx)); end
        checks++; if ((wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx) !== 32'h00200593) begin errors++; $display("FAIL midrst_data1: got=%h exp=00200593", (wr_data.size() > base + 1 ? wr_data[base+1] : 32'hx)); end
        checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL midrst_loadDone: got=%b exp=1", loadDone); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_discard();
        test_too_big();
        test_max_ok();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
